// File: rtl/mac_operand_sequencer.sv
// Sequences A x B through a single 4-bit MAC and streams C row-major.
// Optional cycle counter port enabled by defining MAC_SEQ_PERF_CNT_EN.
module mac_operand_sequencer #(
    parameter int N  = 3,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          start,
    input  logic          a_wr_en,
    input  logic [AW-1:0] a_wr_addr,
    input  logic [3:0]    a_wr_data,
    input  logic          b_wr_en,
    input  logic [AW-1:0] b_wr_addr,
    input  logic [3:0]    b_wr_data,
    output logic [3:0]    mac_w,
    output logic [3:0]    mac_x,
    output logic          mac_load,
    output logic          mac_clear,
    input  logic [9:0]    mac_o,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [9:0]    res_data,
    output logic [1:0]    res_row,
    output logic [1:0]    res_col,
    output logic          busy,
`ifdef MAC_SEQ_PERF_CNT_EN
    output logic [15:0]   cycle_cnt,
`endif
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACC,
        S_CAP,
        S_OUT
    } state_t;

    localparam logic [1:0]  LAST = 2'(N - 1);
    localparam logic [AW:0] NN   = (AW + 1)'(N * N);

    state_t     state, state_n;
    logic [1:0] i, j, k;
    logic [1:0] i_n, j_n, k_n;
    logic       acc_n;
    logic       last_elem;
    logic [3:0] w_n, x_n;

    logic [3:0] a_mem [N*N];
    logic [3:0] b_mem [N*N];

    function automatic logic [AW-1:0] idx(input logic [1:0] r,
                                          input logic [1:0] c);
        return AW'(r) * AW'(N) + AW'(c);
    endfunction

    assign last_elem = (i == LAST) && (j == LAST);
    assign busy      = (state != S_IDLE);

    // Next state and i/j/k counter updates
    always_comb begin
        state_n = state;
        i_n     = i;
        j_n     = j;
        k_n     = k;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_CLR;
                    i_n     = '0;
                    j_n     = '0;
                    k_n     = '0;
                end
            end
            S_CLR: begin
                state_n = S_ACC;
                k_n     = '0;
            end
            S_ACC: begin
                if (k == LAST) state_n = S_CAP;
                else           k_n     = k + 2'd1;
            end
            S_CAP: state_n = S_OUT;
            S_OUT: begin
                if (res_ready) begin
                    if (last_elem) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_CLR;
                        if (j == LAST) begin
                            j_n = '0;
                            i_n = i + 2'd1;
                        end else begin
                            j_n = j + 2'd1;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Operands for the next cycle; zero whenever the MAC is not loading
    always_comb begin
        acc_n = (state_n == S_ACC);
        w_n   = '0;
        x_n   = '0;
        if (acc_n) begin
            w_n = a_mem[idx(i_n, k_n)];
            x_n = b_mem[idx(k_n, j_n)];
        end
    end

    // State, counters and registered MAC/result outputs
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= S_IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            mac_w     <= '0;
            mac_x     <= '0;
            mac_load  <= 1'b0;
            mac_clear <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_row   <= '0;
            res_col   <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            i         <= i_n;
            j         <= j_n;
            k         <= k_n;
            mac_w     <= w_n;
            mac_x     <= x_n;
            mac_load  <= acc_n;
            mac_clear <= (state_n == S_CLR);
            res_valid <= (state_n == S_OUT);
            done      <= (state == S_OUT) && res_ready && last_elem;
            if (state == S_CAP) begin
                res_data <= mac_o;
                res_row  <= i;
                res_col  <= j;
            end
        end
    end

    // Matrix storage: writable only while idle and in range
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int n = 0; n < N * N; n++) begin
                a_mem[n] <= '0;
                b_mem[n] <= '0;
            end
        end else if (state == S_IDLE) begin
            if (a_wr_en && ({1'b0, a_wr_addr} < NN))
                a_mem[a_wr_addr] <= a_wr_data;
            if (b_wr_en && ({1'b0, b_wr_addr} < NN))
                b_mem[b_wr_addr] <= b_wr_data;
        end
    end

`ifdef MAC_SEQ_PERF_CNT_EN
    // Busy-cycle counter, restarted on each accepted start, saturating
    always_ff @(posedge clk) begin
        if (clear) begin
            cycle_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (start) cycle_cnt <= '0;
        end else if (cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer (N=3).
// Includes a behavioural MAC and a matrix-product reference model.
module tb_mac_operand_sequencer;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          clear;
    logic          start;
    logic          a_wr_en;
    logic [AW-1:0] a_wr_addr;
    logic [3:0]    a_wr_data;
    logic          b_wr_en;
    logic [AW-1:0] b_wr_addr;
    logic [3:0]    b_wr_data;
    logic [3:0]    mac_w;
    logic [3:0]    mac_x;
    logic          mac_load;
    logic          mac_clear;
    logic [9:0]    mac_o = '0;
    logic          res_valid;
    logic          res_ready;
    logic [9:0]    res_data;
    logic [1:0]    res_row;
    logic [1:0]    res_col;
    logic          busy;
    logic          done;
`ifdef MAC_SEQ_PERF_CNT_EN
    logic [15:0]   cycle_cnt;
`endif

    int errors = 0;
    int checks = 0;

    int cur_a [NN];
    int cur_b [NN];
    int exp_c [NN];

    typedef struct {
        int a [NN];
        int b [NN];
        int c [NN];
    } vec_t;

    vec_t tbl [5];

    mac_operand_sequencer #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .a_wr_en   (a_wr_en),
        .a_wr_addr (a_wr_addr),
        .a_wr_data (a_wr_data),
        .b_wr_en   (b_wr_en),
        .b_wr_addr (b_wr_addr),
        .b_wr_data (b_wr_data),
        .mac_w     (mac_w),
        .mac_x     (mac_x),
        .mac_load  (mac_load),
        .mac_clear (mac_clear),
        .mac_o     (mac_o),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_row   (res_row),
        .res_col   (res_col),
        .busy      (busy),
`ifdef MAC_SEQ_PERF_CNT_EN
        .cycle_cnt (cycle_cnt),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    // Behavioural MAC unit: clear wins over load
    always @(posedge clk) begin
        if (mac_clear)     mac_o <= '0;
        else if (mac_load) mac_o <= mac_o + {6'd0, mac_w} * {6'd0, mac_x};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({mac_w, mac_x, mac_load, mac_clear, res_valid,
                     res_data, res_row, res_col, busy, done});
    endfunction

    task automatic model();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                exp_c[r*N+c] = 0;
                for (int m = 0; m < N; m++)
                    exp_c[r*N+c] += cur_a[r*N+m] * cur_b[m*N+c];
            end
    endtask

    task automatic load_mats();
        for (int n = 0; n < NN; n++) begin
            a_wr_en   = 1'b1;
            a_wr_addr = AW'(n);
            a_wr_data = 4'(cur_a[n]);
            b_wr_en   = 1'b1;
            b_wr_addr = AW'(n);
            b_wr_data = 4'(cur_b[n]);
            tick();
        end
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
        tick();
    endtask

    task automatic run_mult(input string tag, input int stall_idx,
                            input int stall_len, input bit rnd,
                            input int poke_at);
        int n, dn, cyc, lat, stall_left, clr_n, ld_n, ld_run, badpat;
        n = 0; dn = 0; lat = -1; stall_left = stall_len;
        clr_n = 0; ld_n = 0; ld_run = 0; badpat = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 2000) begin
            if (res_valid && lat < 0) lat = cyc;
            if (mac_clear && mac_load) badpat++;
            if (mac_clear) begin
                if (clr_n > 0 && ld_run != N) badpat++;
                clr_n++;
                ld_run = 0;
            end
            if (mac_load) begin
                ld_n++;
                ld_run++;
            end
            if (done) begin
                dn++;
`ifdef MAC_SEQ_PERF_CNT_EN
                if (!rnd && stall_len == 0 && poke_at < 0)
                    chk({tag, " cycle_cnt"}, int'(cycle_cnt), NN * (N + 3));
`endif
                break;
            end
            start     = (cyc == poke_at);
            a_wr_en   = (cyc == poke_at);
            a_wr_addr = '0;
            a_wr_data = 4'd7;
            if (res_valid) begin
                if (n == stall_idx && stall_left > 0) begin
                    res_ready = 1'b0;
                    chk({tag, " stall_data"}, int'(res_data), exp_c[n]);
                    stall_left--;
                end else begin
                    res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (res_ready) begin
                    chk({tag, " data"}, int'(res_data), exp_c[n]);
                    chk({tag, " row"}, int'(res_row), n / N);
                    chk({tag, " col"}, int'(res_col), n % N);
                    n++;
                end
            end else begin
                res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            tick();
            cyc++;
        end
        start   = 1'b0;
        a_wr_en = 1'b0;
        chk({tag, " done_seen"}, dn, 1);
        chk({tag, " count"}, n, NN);
        chk({tag, " mac_pattern"}, badpat, 0);
        chk({tag, " loads"}, ld_n, NN * N);
        chk({tag, " clears"}, clr_n, NN);
        if (!rnd && poke_at < 0)
            chk({tag, " latency"}, lat, N + 3);
        tick();
        chk({tag, " done_pulse"}, int'(done), 0);
        chk({tag, " idle"}, int'(busy), 0);
    endtask

    initial begin
        int hs, guard, seen;

        tbl[0].a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        tbl[0].b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        tbl[0].c = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        tbl[1].a = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
        tbl[1].b = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
        tbl[1].c = '{675, 675, 675, 675, 675, 675, 675, 675, 675};
        tbl[2].a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        tbl[2].b = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        tbl[2].c = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        tbl[3].a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        tbl[3].b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        tbl[3].c = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
        tbl[4].a = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        tbl[4].b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        tbl[4].c = '{12, 15, 18, 12, 15, 18, 12, 15, 18};

        clear = 1'b1; start = 1'b0; res_ready = 1'b1;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        tick();
        tick();
        clear = 1'b0;
        chk("reset_outs", all_outs(), 0);
`ifdef MAC_SEQ_PERF_CNT_EN
        chk("reset_cnt", int'(cycle_cnt), 0);
`endif

        for (int t = 0; t < 5; t++) begin
            cur_a = tbl[t].a;
            cur_b = tbl[t].b;
            exp_c = tbl[t].c;
            load_mats();
            run_mult($sformatf("vec%0d", t), -1, 0, 1'b0, -1);
        end

        cur_a = tbl[0].a;
        cur_b = tbl[0].b;
        exp_c = tbl[0].c;
        load_mats();
        run_mult("stall", 4, 5, 1'b0, -1);
        run_mult("poke", -1, 0, 1'b0, 3);
        a_wr_en = 1'b1; a_wr_addr = AW'(12); a_wr_data = 4'd15;
        tick();
        a_wr_en = 1'b0;
        run_mult("after_poke", -1, 0, 1'b0, -1);

        // Reset during ACC of element (0,2)
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        hs = 0;
        guard = 0;
        while (guard < 200 && !(hs == 2 && mac_load)) begin
            if (res_valid) hs++;
            tick();
            guard++;
        end
        chk("reach_acc02", int'(guard < 200), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("midclr_outs", all_outs(), 0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (done || res_valid || busy) seen++;
            tick();
        end
        chk("midclr_quiet", seen, 0);
        for (int n = 0; n < NN; n++) exp_c[n] = 0;
        run_mult("zeroed", -1, 0, 1'b0, -1);
        load_mats();
        exp_c = tbl[0].c;
        run_mult("reload", -1, 0, 1'b0, -1);

        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < NN; n++) begin
                cur_a[n] = int'($urandom_range(0, 15));
                cur_b[n] = int'($urandom_range(0, 15));
            end
            model();
            load_mats();
            run_mult($sformatf("rand%0d", r), -1, 0, 1'b1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Initiator side of the 4-bit MAC interface (w, x, load, clear in; 10-bit accumulated o out).
- Holds two N x N matrices of 4-bit unsigned elements, A and B, loaded through simple write ports.
- On start, computes C = A x B by driving one MAC unit once per output element, then streams each 10-bit result out over a valid/ready port in row-major order.
- Sits between the host/loader and the MAC datapath in the matrix multiplication accelerator.

Parameters:
- N, 3, matrix dimension; legal range 1..4. 4 x 15 x 15 = 900 fits the 10-bit accumulator.
- AW, 4, element address width; must satisfy 2^AW >= N*N. Address = row*N + col.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  synchronous active-high reset.
- start  input  1  begin multiplication; sampled only in IDLE.
- a_wr_en  input  1  write strobe for matrix A.
- a_wr_addr  input  AW  A element address.
- a_wr_data  input  4  A element value.
- b_wr_en  input  1  write strobe for matrix B.
- b_wr_addr  input  AW  B element address.
- b_wr_data  input  4  B element value.
- mac_w  output  4  A operand to the MAC.
- mac_x  output  4  B operand to the MAC.
- mac_load  output  1  MAC accumulate enable.
- mac_clear  output  1  MAC accumulator clear.
- mac_o  input  10  MAC accumulated value.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  10  C[i][j].
- res_row  output  2  i of the current result.
- res_col  output  2  j of the current result.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final result handshake.

Behaviour:
- Reset (clear=1 at a clk edge):
  - Returns to IDLE.
  - Drives all outputs to 0.
  - Zeroes both matrices and the i/j/k counters.
  - Takes priority over every other input, including a reset mid-operation. Any partial result is discarded and no done pulse is issued.
- MAC contract: on each edge the MAC does o <= 0 if mac_clear, else o <= o + w*x if mac_load, else holds. mac_clear wins when both are high. The sequencer never asserts both together.
- Matrix writes are accepted only in IDLE.
  - Writes while busy are ignored.
  - Addresses >= N*N are ignored.
  - A and B may be written in the same cycle.
- All mac_* and res_* outputs are registered.
- FSM states:
  - IDLE: busy=0. start=1 clears i, j, k and goes to CLR. A start seen while busy is ignored.
  - CLR: one cycle with mac_clear=1, mac_load=0. Goes to ACC.
  - ACC: N cycles with mac_load=1, mac_w=A[i][k], mac_x=B[k][j], k = 0..N-1. After k=N-1 goes to CAP. Operands are 0 whenever mac_load=0.
  - CAP: one cycle with mac_load=0. The final sum is now on mac_o. Latches res_data=mac_o, res_row=i, res_col=j. Goes to OUT.
  - OUT: res_valid=1, and res_data/res_row/res_col hold stable until res_valid & res_ready.
    - On the handshake, res_valid drops on the next edge.
    - If (i,j) = (N-1,N-1): go to IDLE with done=1 for that one cycle.
    - Otherwise advance j, wrap j to 0 and increment i, then go to CLR.
- Latency:
  - Per element: 1 + N + 1 cycles from entering CLR to res_valid rising, plus the consumer stall.
  - With res_ready held high, an element completes every N+3 cycles, and first res_valid appears N+3 cycles after start is accepted.
- Arithmetic is unsigned. No overflow is possible for N<=4.
- res_ready while res_valid=0 is ignored.

Optional Feature:
- Macro: MAC_SEQ_PERF_CNT_EN.
- When defined:
  - Adds output port cycle_cnt (16 bits).
  - Cleared to 0 when start is accepted, incremented every cycle while busy, saturating at 16'hFFFF.
  - Holds its value in IDLE and resets to 0 on clear.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- N=3, A=identity, B=1..9 row-major, res_ready=1 -> results 1,2,3,4,5,6,7,8,9 in order (0,0)..(2,2); one done pulse; first res_valid 6 cycles after start accepted.
- N=3, all A and B elements 15 -> nine results of 675; the mac_clear/mac_load pattern of 1 clear + 3 loads repeats per element.
- Results 1..9 case with res_ready low for 5 cycles on element (1,1) -> res_valid and res_data=5 held stable throughout; no element lost or duplicated.
- clear asserted during ACC of element (0,2) -> next cycle all outputs 0 and IDLE; a fresh start after reloading the matrices yields a correct full result set.
- start pulsed while busy, and a_wr_en to address 0 with data 7 while busy -> no restart, A[0][0] unchanged, results match the original matrices.
- With MAC_SEQ_PERF_CNT_EN defined, N=3, res_ready=1 -> cycle_cnt = 9*6 = 54 at done.
